data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder that sits on the CPU's `m_data_*` port and answers the pipeline's M-stage requests. It provides:
- a word-organised RAM with byte-lane writes and a same-cycle combinational read;
- a write-trace FIFO that records every committed store as `{pc, address, merged word, byteen}`.

The testbench monitor drains the trace FIFO through a valid/ready handshake to compare stores against the golden model.

## Interface
Parameters:
- `ADDR_W`, 12, word-address width (2^ADDR_W words, byte range 0 .. 4·2^ADDR_W−1)
- `TRACE_DEPTH`, 8, trace FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately
- `m_data_addr`  in  32  byte address from CPU; bits [1:0] always 0
- `m_data_wdata`  in  32  lane-aligned write data
- `m_data_byteen`  in  4  byte-lane write enables; 0 means read/no-op
- `m_inst_addr`  in  32  PC of the M-stage instruction, used for the trace only
- `m_data_rdata`  out  32  word at `m_data_addr`, combinational
- `trace_valid`  out  1  FIFO head entry is valid
- `trace_ready`  in  1  monitor accepts the head entry
- `trace_pc`  out  32  head: store PC
- `trace_addr`  out  32  head: word-aligned byte address
- `trace_data`  out  32  head: full word after the merge
- `trace_byteen`  out  4  head: lanes written
- `trace_count`  out  $clog2(TRACE_DEPTH)+1  entries held
- `trace_overflow`  out  1  sticky: at least one store trace was dropped

## Operation
- **Word index.** `idx = m_data_addr[ADDR_W+1:2]`. The request is in range when `m_data_addr[31:ADDR_W+2] == 0`.
- **Read.**
  - In range: `m_data_rdata = mem[idx]`.
  - Out of range: `m_data_rdata = 0`.
  - `m_data_rdata` does not depend on `byteen`; the CPU selects bytes and halfwords itself.
- **Write.** A write occurs on a rising edge when `byteen != 0` and the request is in range.
  - `merged[8k+7:8k] = byteen[k] ? wdata[8k+7:8k] : mem[idx][8k+7:8k]` for k = 0..3.
  - `mem[idx] <= merged`.
  - An out-of-range write is ignored: no memory change and no trace entry.
- **Trace push.** Every committed write pushes `{m_inst_addr, {m_data_addr[31:2], 2'b00}, merged, byteen}`.
- **Trace pop.** The head entry is popped on an edge where `trace_valid && trace_ready`.
- **FIFO boundary cases:**
  - Empty FIFO with push and no pop: the entry becomes head next cycle. There is no same-cycle bypass.
  - Full FIFO with push and pop in the same cycle: both happen and the count stays at TRACE_DEPTH.
  - Full FIFO with push and no pop: the entry is dropped and `trace_overflow <= 1`. `trace_overflow` holds until reset.
  - Pop on an empty FIFO is impossible because `trace_valid` = 0.
  - Read and write pointers wrap modulo TRACE_DEPTH. Count range is 0..TRACE_DEPTH.
- **Reset state (`reset` = 0):**
  - all memory words 0, so `m_data_rdata` = 0;
  - FIFO pointers and `trace_count` = 0, `trace_valid` = 0;
  - `trace_pc`, `trace_addr`, `trace_data` = 0 and `trace_byteen` = 0;
  - `trace_overflow` = 0.
- **Reset asserted mid-operation** discards all pending entries and any write on that edge.

## Timing
- **Read latency:** 0 cycles. A write becomes visible to reads from the cycle after its edge.
- **Back-to-back stores to the same word** merge correctly, because the second merge reads the word the first store updated.
- **Trace latency:** an entry pushed at edge N is visible at the head after edge N when the FIFO was empty.
- **Head outputs:** registered FIFO storage. They remain stable while `trace_valid && !trace_ready`.
- **`trace_count`** updates on the same edge as push and pop.

## Structure
- **Shared constants package `mem_pkg`:** `BYTEEN_NONE` = 4'b0000, `BYTEEN_WORD` = 4'b1111, and the trace-entry field widths. The CPU byte-enable unit uses the same constants.
- **Sub-module `trace_fifo`:** generic synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, full, empty, count, and the sticky overflow flag. `data_mem_responder` instantiates it with WIDTH = 100.
- **Memory array:** inline `reg [31:0] mem [0:2**ADDR_W-1]`.

## Test plan
- **Word write:**
  - Stimulus: addr 0x0000_0010, wdata 0xDEAD_BEEF, byteen 1111 at PC 0x3000.
  - Next cycle: rdata = 0xDEAD_BEEF.
  - Trace head: {0x3000, 0x10, 0xDEAD_BEEF, 1111}.
- **Lane merge:**
  - Stimulus: preload 0x1122_3344 at 0x20, then byteen 0010 with wdata 0x0000_AA00, then byteen 1000 with wdata 0xBB00_0000 on the next cycle.
  - After the first store: rdata = 0x1122_AA44.
  - After the second store: rdata = 0xBB22_AA44.
  - Trace entries carry those merged words in order.
- **Out of range:**
  - Stimulus: addr 0x0001_0000 with ADDR_W = 12, byteen 1111.
  - Required: rdata = 0, no memory change, `trace_count` unchanged.
- **FIFO full:**
  - Stimulus: TRACE_DEPTH = 8, `trace_ready` = 0, nine stores.
  - Required: count = 8 and overflow = 1. The first eight entries drain in order once `trace_ready` = 1.
- **Full with simultaneous push and pop:**
  - Stimulus: FIFO full, `trace_ready` = 1, one store in the same cycle.
  - Required: count stays 8, overflow stays 0, the new entry lands at the tail.
- **Async reset mid-stream:**
  - Stimulus: assert `reset` = 0 between edges with 3 entries pending.
  - Required, immediately: `trace_valid` = 0, count = 0, rdata at previously written addresses = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared data-memory constants and the trace-entry payload layout.
package mem_pkg;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    localparam int unsigned TR_PC_W     = 32;
    localparam int unsigned TR_ADDR_W   = 32;
    localparam int unsigned TR_DATA_W   = 32;
    localparam int unsigned TR_BYTEEN_W = 4;
    localparam int unsigned TRACE_W     = TR_PC_W + TR_ADDR_W + TR_DATA_W + TR_BYTEEN_W;

    typedef struct packed {
        logic [TR_PC_W-1:0]     pc;
        logic [TR_ADDR_W-1:0]   addr;
        logic [TR_DATA_W-1:0]   data;
        logic [TR_BYTEEN_W-1:0] byteen;
    } trace_entry_t;

    // Byte-lane merge of new write data over an existing word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with registered storage, occupancy count and sticky overflow.
module trace_fifo #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage_q [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push && !do_push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) storage_q[i] <= '0;
        end else if (do_push) begin
            storage_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata    = storage_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: byte-lane RAM with combinational read and a store-trace FIFO.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    m_data_addr,
    input  logic [31:0]                    m_data_wdata,
    input  logic [3:0]                     m_data_byteen,
    input  logic [31:0]                    m_inst_addr,
    output logic [31:0]                    m_data_rdata,
    output logic                           trace_valid,
    input  logic                           trace_ready,
    output logic [31:0]                    trace_pc,
    output logic [31:0]                    trace_addr,
    output logic [31:0]                    trace_data,
    output logic [3:0]                     trace_byteen,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);

    localparam int unsigned MEM_WORDS = 2 ** ADDR_W;

    logic [31:0]       mem [0:MEM_WORDS-1];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              wr_en;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    trace_entry_t      push_entry;
    trace_entry_t      head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^m_data_addr[1:0];

    assign idx      = m_data_addr[ADDR_W+1:2];
    assign in_range = (m_data_addr[31:ADDR_W+2] == '0);
    assign cur_word = mem[idx];
    assign merged   = merge_lanes(cur_word, m_data_wdata, m_data_byteen);
    assign wr_en    = (m_data_byteen != BYTEEN_NONE) && in_range;

    assign m_data_rdata = in_range ? cur_word : 32'h0;

    // Whole array clears on reset so stale data never leaks across runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[idx] <= merged;
        end
    end

    always_comb begin
        push_entry        = '0;
        push_entry.pc     = m_inst_addr;
        push_entry.addr   = {m_data_addr[31:2], 2'b00};
        push_entry.data   = merged;
        push_entry.byteen = m_data_byteen;
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_en),
        .pop      (trace_ready),
        .wdata    (push_entry),
        .rdata    (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (trace_count),
        .overflow (trace_overflow)
    );

    assign trace_valid  = !fifo_empty;
    assign trace_pc     = head_entry.pc;
    assign trace_addr   = head_entry.addr;
    assign trace_data   = head_entry.data;
    assign trace_byteen = head_entry.byteen;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_byteen;
    logic [3:0]  trace_count;
    logic        trace_overflow;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_responder #(.ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_byteen   (trace_byteen),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic store(input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        m_inst_addr   = pc;
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        @(posedge clk);
        #1;
        m_data_byteen = 4'b0000;
    endtask

    task automatic pop_check(input logic [31:0] pc, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        chk("head_valid",  64'(trace_valid),  64'(1'b1));
        chk("head_pc",     64'(trace_pc),     64'(pc));
        chk("head_addr",   64'(trace_addr),   64'(addr));
        chk("head_data",   64'(trace_data),   64'(data));
        chk("head_byteen", 64'(trace_byteen), 64'(be));
        trace_ready = 1'b1;
        @(posedge clk);
        #1;
        trace_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        trace_ready   = 1'b0;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'b0000;
        m_inst_addr   = 32'h0;
        #12;
        chk("rst_rdata",    64'(m_data_rdata),   64'h0);
        chk("rst_valid",    64'(trace_valid),    64'h0);
        chk("rst_count",    64'(trace_count),    64'h0);
        chk("rst_pc",       64'(trace_pc),       64'h0);
        chk("rst_addr",     64'(trace_addr),     64'h0);
        chk("rst_data",     64'(trace_data),     64'h0);
        chk("rst_byteen",   64'(trace_byteen),   64'h0);
        chk("rst_overflow", 64'(trace_overflow), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Word write
        store(32'h3000, 32'h10, 32'hDEAD_BEEF, 4'b1111);
        chk("word_rdata", 64'(m_data_rdata), 64'hDEAD_BEEF);
        chk("word_count", 64'(trace_count),  64'd1);
        pop_check(32'h3000, 32'h10, 32'hDEAD_BEEF, 4'b1111);

        // Lane merge with back-to-back stores
        store(32'h3004, 32'h20, 32'h1122_3344, 4'b1111);
        store(32'h3008, 32'h20, 32'h0000_AA00, 4'b0010);
        chk("merge1_rdata", 64'(m_data_rdata), 64'h1122_AA44);
        store(32'h300C, 32'h20, 32'hBB00_0000, 4'b1000);
        chk("merge2_rdata", 64'(m_data_rdata), 64'hBB22_AA44);
        chk("merge_count",  64'(trace_count),  64'd3);
        pop_check(32'h3004, 32'h20, 32'h1122_3344, 4'b1111);
        pop_check(32'h3008, 32'h20, 32'h1122_AA44, 4'b0010);
        pop_check(32'h300C, 32'h20, 32'hBB22_AA44, 4'b1000);

        // Out-of-range write aliases word 0 if range check is broken
        store(32'h3100, 32'h0001_0000, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_rdata", 64'(m_data_rdata), 64'h0);
        chk("oor_count", 64'(trace_count),  64'h0);
        chk("oor_valid", 64'(trace_valid),  64'h0);
        m_data_addr = 32'h0;
        #1;
        chk("oor_word0", 64'(m_data_rdata), 64'h0);

        // Fill to full, then push and pop on the same edge
        for (int i = 0; i < 8; i++)
            store(32'h4000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'(i), 4'b1111);
        chk("fill_count",    64'(trace_count),    64'd8);
        chk("fill_overflow", 64'(trace_overflow), 64'h0);
        @(negedge clk);
        trace_ready   = 1'b1;
        m_inst_addr   = 32'h5000;
        m_data_addr   = 32'h200;
        m_data_wdata  = 32'hCAFE_F00D;
        m_data_byteen = 4'b0101;
        @(posedge clk);
        #1;
        m_data_byteen = 4'b0000;
        trace_ready   = 1'b0;
        chk("pp_count",    64'(trace_count),    64'd8);
        chk("pp_overflow", 64'(trace_overflow), 64'h0);
        chk("pp_rdata",    64'(m_data_rdata),   64'h00FE_000D);
        for (int i = 1; i < 8; i++)
            pop_check(32'h4000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'(i), 4'b1111);
        pop_check(32'h5000, 32'h200, 32'h00FE_000D, 4'b0101);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Overflow: nine stores into eight slots
        for (int i = 0; i < 9; i++)
            store(32'h6000 + 32'(4 * i), 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
        chk("ovf_count", 64'(trace_count),    64'd8);
        chk("ovf_flag",  64'(trace_overflow), 64'd1);
        for (int i = 0; i < 8; i++)
            pop_check(32'h6000 + 32'(4 * i), 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
        @(negedge clk);
        chk("ovf_drained_valid", 64'(trace_valid),    64'h0);
        chk("ovf_drained_count", 64'(trace_count),    64'h0);
        chk("ovf_sticky",        64'(trace_overflow), 64'd1);
        m_data_addr = 32'h320;
        #1;
        chk("ovf_9th_mem", 64'(m_data_rdata), 64'hA8);

        // Asynchronous reset between edges with three entries pending
        for (int i = 0; i < 3; i++)
            store(32'h7000 + 32'(4 * i), 32'h400 + 32'(4 * i), 32'h55 + 32'(i), 4'b1111);
        chk("ar_pre_count", 64'(trace_count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid",    64'(trace_valid),    64'h0);
        chk("ar_count",    64'(trace_count),    64'h0);
        chk("ar_overflow", 64'(trace_overflow), 64'h0);
        m_data_addr = 32'h400;
        #1;
        chk("ar_rdata_400", 64'(m_data_rdata), 64'h0);
        m_data_addr = 32'h408;
        #1;
        chk("ar_rdata_408", 64'(m_data_rdata), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
